flux_rr_scheduler: RTL and testbench
====================================

FLUX_RR_SCHEDULER -- requirements
Module: flux_rr_scheduler

Interface
REQ-001 The block SHALL have parameter FLUX, default 2: number of independent data fluxes sharing one actor datapath.
REQ-002 The block SHALL have parameter BURST, default 4: maximum consecutive firings granted to one flux before rotation (legal range 1..255).
REQ-003 The block SHALL have parameter TAG_WIDTH, default max(1,$clog2(FLUX)): width of the flux tag.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, FLUX bits: bit i high = flux i has its firing condition satisfied (input tokens present, output not full).
REQ-007 The block SHALL have port fire, input, 1 bit: the actor consumed/produced one token for the granted flux this cycle.
REQ-008 The block SHALL have port last, input, 1 bit: qualifies fire; the fire completes the current job of the granted flux.
REQ-009 The block SHALL have port grant_valid, output, 1 bit: registered; a grant is held.
REQ-010 The block SHALL have port tag, output, TAG_WIDTH bits: registered; index of the granted flux.
REQ-011 The block SHALL have port grant, output, FLUX bits: one-hot of tag, gated by grant_valid.
REQ-012 The block SHALL have port fire_count, output, 16 bits: total accepted firings, wraps 0xFFFF->0.
REQ-013 The block SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 The FSM SHALL have two states: SCAN (no grant held) and HOLD (grant held); grant_valid SHALL be 1 exactly in HOLD.
REQ-015 The block SHALL keep a rotation pointer ptr (TAG_WIDTH bits, 0..FLUX-1) and a burst counter bcnt (8 bits).
REQ-016 In SCAN with req!=0, the block SHALL select the first set req bit searching ptr, ptr+1, ..., wrapping modulo FLUX, load it into tag, clear bcnt, and enter HOLD on the next edge.
REQ-017 Grant latency SHALL be one cycle: req sampled in SCAN at edge n yields grant_valid=1 after edge n.
REQ-018 In SCAN with req==0, the block SHALL remain in SCAN with tag unchanged.
REQ-019 An accepted fire SHALL be fire=1 while in HOLD and req[tag]=1; each accepted fire SHALL increment fire_count and bcnt.
REQ-020 In HOLD, the grant SHALL be released (enter SCAN, ptr<=tag+1 mod FLUX) on: accepted fire with last=1; accepted fire with bcnt==BURST-1; or req[tag]=0 with no fire.
REQ-021 Otherwise the block SHALL remain in HOLD with tag stable.
REQ-022 On release, no re-grant SHALL occur in the same cycle; the next grant SHALL appear no earlier than two cycles after the releasing edge sampled it (SCAN cycle + registered grant).
REQ-023 With BURST=1, every accepted fire SHALL release the grant.
REQ-024 fire=1 in SCAN, or fire=1 in HOLD with req[tag]=0, SHALL set err, SHALL NOT count, and SHALL NOT change state except per REQ-020.
REQ-025 last=1 with fire=0 SHALL be ignored.
REQ-026 Requests from other fluxes arriving during HOLD SHALL NOT preempt the grant.
REQ-027 FLUX=1 SHALL degenerate to a single flux with ptr and tag fixed at 0.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force: state=SCAN, grant_valid=0, grant=0, tag=0, ptr=0, bcnt=0, fire_count=0, err=0.
REQ-029 Reset asserted mid-HOLD SHALL drop the grant immediately, without waiting for a clock edge; after deassertion, scanning SHALL restart from ptr=0.

Verification
REQ-030 Basic grant: FLUX=2, req=2'b01 -> next cycle grant_valid=1, tag=0, grant=2'b01; fire+last -> following cycle grant_valid=0, ptr=1.
REQ-031 Round-robin fairness: FLUX=2, req=2'b11 held, fire every HOLD cycle, last=1 -> tags alternate 0,1,0,1 with one SCAN cycle between grants; fire_count increments once per grant.
REQ-032 Burst limit: BURST=4, req=2'b11, fire continuous, last=0 -> flux 0 receives exactly 4 fires, then flux 1 is granted.
REQ-033 Request withdrawal: in HOLD on tag=1, req[1] drops with fire=0 -> SCAN next cycle, ptr=0, err=0.
REQ-034 Protocol error: fire=1 while grant_valid=0 -> err=1 and stays 1; fire_count unchanged.
REQ-035 Reset and wrap: fire_count preloaded to 0xFFFF via 65535 fires, one more fire -> 0x0000; rst=0 mid-HOLD -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler: round-robin grant of one actor datapath across FLUX fluxes,
// with a per-grant burst limit, firing counter and sticky protocol-error flag.
module flux_rr_scheduler #(
    parameter int FLUX      = 2,
    parameter int BURST     = 4,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic                 fire,
    input  logic                 last,
    output logic                 grant_valid,
    output logic [TAG_WIDTH-1:0] tag,
    output logic [FLUX-1:0]      grant,
    output logic [15:0]          fire_count,
    output logic                 err
);
    typedef enum logic {SCAN, HOLD} state_t;

    localparam logic [TAG_WIDTH:0]   FLUX_W   = (TAG_WIDTH+1)'(FLUX);
    localparam logic [TAG_WIDTH-1:0] TAG_LAST = TAG_WIDTH'(FLUX-1);
    localparam logic [7:0]           BURST_M1 = 8'(BURST-1);

    state_t               state_q, state_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d, ptr_q, ptr_d, off, pick, tag_inc;
    logic [TAG_WIDTH:0]   sum, sum_wrap;
    logic [2*FLUX-1:0]    req2;
    logic [FLUX-1:0]      rot, onehot;
    logic [7:0]           bcnt_q, bcnt_d;
    logic [15:0]          fire_count_q, fire_count_d;
    logic                 err_q, err_d;
    logic                 hold, req_tag, acc, rel;

    // Rotate requests so bit 0 is the flux at ptr; the lowest set bit is the winner.
    always_comb begin
        req2     = {req, req} >> ptr_q;
        rot      = req2[FLUX-1:0];
        off      = '0;
        for (int i = FLUX-1; i >= 0; i--)
            if (rot[i]) off = TAG_WIDTH'(i);
        sum      = {1'b0, ptr_q} + {1'b0, off};
        sum_wrap = sum - FLUX_W;
        pick     = (sum >= FLUX_W) ? sum_wrap[TAG_WIDTH-1:0] : sum[TAG_WIDTH-1:0];
    end

    always_comb begin
        hold         = state_q == HOLD;
        onehot       = FLUX'(1) << tag_q;
        req_tag      = |(req & onehot);
        acc          = hold & fire & req_tag;
        tag_inc      = (tag_q == TAG_LAST) ? '0 : tag_q + 1'b1;
        rel          = acc ? (last | (bcnt_q == BURST_M1)) : (hold & ~fire & ~req_tag);
        state_d      = hold ? (rel ? SCAN : HOLD) : ((|req) ? HOLD : SCAN);
        tag_d        = (!hold && (|req)) ? pick : tag_q;
        ptr_d        = rel ? tag_inc : ptr_q;
        bcnt_d       = hold ? bcnt_q + 8'(acc) : 8'd0;
        fire_count_d = fire_count_q + 16'(acc);
        err_d        = err_q | (fire & ~(hold & req_tag));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SCAN;
            tag_q        <= '0;
            ptr_q        <= '0;
            bcnt_q       <= '0;
            fire_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            ptr_q        <= ptr_d;
            bcnt_q       <= bcnt_d;
            fire_count_q <= fire_count_d;
            err_q        <= err_d;
        end
    end

    assign grant_valid = hold;
    assign tag         = tag_q;
    assign grant       = hold ? onehot : '0;
    assign fire_count  = fire_count_q;
    assign err         = err_q;
endmodule

// File: tb/tb_flux_rr_scheduler.sv
// tb_flux_rr_scheduler: directed and randomized checks of flux_rr_scheduler
// against a transaction-level reference model (BURST=4 main, BURST=255 for counter wrap).
module tb_flux_rr_scheduler;
    localparam int FLUX = 2;

    typedef struct {
        bit hold;
        int tag;
        int ptr;
        int bcnt;
        int cnt;
        bit err;
    } mdl_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [FLUX-1:0] req = '0, req_w = '0;
    logic            fire = 1'b0, last = 1'b0, fire_w = 1'b0;
    logic            gv, gv_w, err, err_w;
    logic [0:0]      tag, tag_w;
    logic [FLUX-1:0] grant, grant_w;
    logic [15:0]     fcnt, fcnt_w;
    mdl_t            m, mw;
    int              n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    flux_rr_scheduler #(.FLUX(FLUX), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .fire(fire), .last(last),
        .grant_valid(gv), .tag(tag), .grant(grant), .fire_count(fcnt), .err(err)
    );

    flux_rr_scheduler #(.FLUX(FLUX), .BURST(255)) dut_w (
        .clk(clk), .rst(rst), .req(req_w), .fire(fire_w), .last(1'b0),
        .grant_valid(gv_w), .tag(tag_w), .grant(grant_w), .fire_count(fcnt_w), .err(err_w)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic mdl_t reset_m();
        mdl_t r;
        r.hold = 0; r.tag = 0; r.ptr = 0; r.bcnt = 0; r.cnt = 0; r.err = 0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t c, input logic [FLUX-1:0] r, input logic f,
                                  input logic l, input int burst);
        mdl_t n;
        n = c;
        if (!c.hold) begin
            if (f) n.err = 1;
            for (int k = 0; k < FLUX; k++)
                if (!n.hold && r[(c.ptr + k) % FLUX]) begin
                    n.hold = 1;
                    n.tag  = (c.ptr + k) % FLUX;
                    n.bcnt = 0;
                end
        end else if (f && r[c.tag]) begin
            n.cnt  = (c.cnt + 1) % 65536;
            n.bcnt = c.bcnt + 1;
            if (l || n.bcnt == burst) begin
                n.hold = 0;
                n.ptr  = (c.tag + 1) % FLUX;
            end
        end else if (f) begin
            n.err = 1;
        end else if (!r[c.tag]) begin
            n.hold = 0;
            n.ptr  = (c.tag + 1) % FLUX;
        end
        return n;
    endfunction

    task automatic check_main(input string p);
        check({p, ".gv"}, 32'(gv), 32'(m.hold));
        check({p, ".tag"}, 32'(tag), 32'(m.tag));
        check({p, ".grant"}, 32'(grant), m.hold ? 32'(1 << m.tag) : 32'd0);
        check({p, ".cnt"}, 32'(fcnt), 32'(m.cnt));
        check({p, ".err"}, 32'(err), 32'(m.err));
    endtask

    task automatic cyc(input logic [FLUX-1:0] r, input logic f, input logic l, input bit ck,
                       input string p);
        req = r; fire = f; last = l;
        @(posedge clk);
        m  = step(m, r, f, l, 4);
        mw = step(mw, req_w, fire_w, 1'b0, 255);
        #1;
        if (ck) check_main(p);
    endtask

    task automatic do_reset();
        req = '0; fire = 0; last = 0; req_w = '0; fire_w = 0;
        rst = 0;
        m = reset_m(); mw = reset_m();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        logic [FLUX-1:0] r;
        logic f;
        do_reset();
        check_main("reset");
        // basic grant, release moves ptr to 1
        cyc(2'b01, 0, 0, 1, "basic_grant");
        check("basic_tag0", 32'(tag), 32'd0);
        cyc(2'b01, 1, 1, 1, "basic_release");
        // ptr now 1: both requesting grants flux 1, then withdrawal
        cyc(2'b11, 0, 0, 1, "ptr1_grant");
        check("ptr1_tag", 32'(tag), 32'd1);
        cyc(2'b01, 0, 0, 1, "withdraw");
        cyc(2'b11, 0, 0, 1, "after_withdraw");
        check("withdraw_next_tag0", 32'(tag), 32'd0);
        // burst limit: 4 fires on flux 0, then flux 1
        repeat (4) cyc(2'b11, 1, 0, 1, "burst");
        cyc(2'b11, 0, 0, 1, "burst_next");
        check("burst_tag1", 32'(tag), 32'd1);
        check("burst_cnt4", 32'(fcnt), 32'd5);
        // fairness: fire+last every HOLD cycle
        for (int i = 0; i < 8; i++) cyc(2'b11, m.hold, 1, 1, "rr");
        // other flux does not preempt
        cyc(2'b01, 0, 0, 1, "np_a");
        cyc(2'b11, 0, 0, 1, "np_b");
        cyc(2'b11, 0, 0, 1, "np_c");
        // last without fire ignored; fire in SCAN sets err without counting
        cyc(2'b11, 0, 1, 1, "last_only");
        cyc(2'b11, 1, 1, 1, "rel");
        cyc(2'b00, 1, 0, 1, "err_scan");
        check("err_set", 32'(err), 32'd1);
        cyc(2'b00, 0, 0, 1, "err_sticky");
        // clean random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = 2'($urandom);
            f = m.hold && r[m.tag] && ($urandom_range(0, 3) != 0);
            cyc(r, f, 1'($urandom_range(0, 5) == 0), 1, "rand_clean");
        end
        // random traffic with protocol violations
        do_reset();
        for (int i = 0; i < 1500; i++)
            cyc(2'($urandom), 1'($urandom), 1'($urandom), 1, "rand_err");
        // counter wrap on the BURST=255 instance
        do_reset();
        req_w = 2'b01;
        for (int i = 0; i < 70000 && mw.cnt != 65535; i++) begin
            fire_w = mw.hold;
            cyc(2'b00, 0, 0, 0, "wrap");
        end
        check("wrap_ffff", 32'(fcnt_w), 32'h0000ffff);
        for (int i = 0; i < 4 && !mw.hold; i++) begin
            fire_w = 0;
            cyc(2'b00, 0, 0, 0, "wrap_regrant");
        end
        fire_w = 1;
        cyc(2'b01, 0, 0, 1, "wrap_main_hold");
        check("wrap_zero", 32'(fcnt_w), 32'd0);
        check("wrap_model", 32'(fcnt_w), 32'(mw.cnt));
        check("wrap_err", 32'(err_w), 32'd0);
        check("pre_rst_gv", 32'(gv), 32'd1);
        // asynchronous reset mid-HOLD
        fire_w = 0;
        #2 rst = 0;
        m = reset_m(); mw = reset_m();
        #1;
        check_main("async_rst");
        check("async_rst_gv_w", 32'(gv_w), 32'd0);
        check("async_rst_grant_w", 32'(grant_w), 32'd0);
        check("async_rst_cnt_w", 32'(fcnt_w), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        cyc(2'b11, 0, 0, 1, "post_rst");
        check("post_rst_tag0", 32'(tag), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
